// File: rtl/gnss_carrier_wipeoff_accum_pkg.sv
// Shared definitions for the GNSS carrier wipe-off / integrate-and-dump block:
// default widths, the integration FSM state type and the output clip helper.
package gnss_dsp_pkg;

  localparam int DDS_W_DEF      = 18;
  localparam int IF_W_DEF       = 4;
  localparam int DUMP_LEN_W_DEF = 16;
  localparam int ACC_W_DEF      = 40;
  localparam int OUT_W_DEF      = 16;
  localparam int SHIFT_DEF      = 20;

  // Working width of the clip helper; accumulators up to this width are supported.
  localparam int CLIP_W = 64;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } cwa_state_e;

  typedef struct packed {
    logic                     sat;
    logic signed [CLIP_W-1:0] val;
  } clip_t;

  // Clamp a signed value into the range of an out_w-bit signed number.
  function automatic clip_t sat_clip(input logic signed [CLIP_W-1:0] x,
                                     input int unsigned              out_w);
    logic signed [CLIP_W-1:0] hi_v;
    logic signed [CLIP_W-1:0] lo_v;
    clip_t                    res_v;
    hi_v = (64'sd1 <<< (out_w - 32'd1)) - 64'sd1;
    lo_v = -hi_v - 64'sd1;
    if (x > hi_v) begin
      res_v.sat = 1'b1;
      res_v.val = hi_v;
    end else if (x < lo_v) begin
      res_v.sat = 1'b1;
      res_v.val = lo_v;
    end else begin
      res_v.sat = 1'b0;
      res_v.val = x;
    end
    return res_v;
  endfunction

endpackage

// File: rtl/gnss_carrier_wipeoff_accum_if.sv
// Sample / control / result bundle between the DDS front end, the wipe-off
// accumulator and the tracking loop. The accumulator uses the slave view.
interface gnss_carrier_wipeoff_accum_if
  import gnss_dsp_pkg::*;
#(
  parameter int DDS_W      = DDS_W_DEF,
  parameter int IF_W       = IF_W_DEF,
  parameter int DUMP_LEN_W = DUMP_LEN_W_DEF,
  parameter int OUT_W      = OUT_W_DEF
);
  logic                    INIT_OVER;
  logic                    ENABLE;
  logic [DUMP_LEN_W-1:0]   DUMP_LEN;
  logic signed [IF_W-1:0]  IF_DATA;
  logic                    IF_VALID;
  logic signed [DDS_W-1:0] SINE;
  logic signed [DDS_W-1:0] COSINE;
  logic signed [OUT_W-1:0] OUT_I;
  logic signed [OUT_W-1:0] OUT_Q;
  logic                    OUT_VALID;
  logic                    OUT_READY;
  logic                    OVERRUN;
  logic                    SAT;

  modport master (
    output INIT_OVER, ENABLE, DUMP_LEN, IF_DATA, IF_VALID, SINE, COSINE, OUT_READY,
    input  OUT_I, OUT_Q, OUT_VALID, OVERRUN, SAT
  );

  modport slave (
    input  INIT_OVER, ENABLE, DUMP_LEN, IF_DATA, IF_VALID, SINE, COSINE, OUT_READY,
    output OUT_I, OUT_Q, OUT_VALID, OVERRUN, SAT
  );
endinterface

// File: rtl/gnss_carrier_wipeoff_accum_mult.sv
// Registered signed IF x DDS multiplier (pipeline stage 1). With NEGATE set
// the stored product is negated; at IF_W+DDS_W bits that cannot overflow.
module carrier_mix_mult #(
  parameter int IF_W   = 4,
  parameter int DDS_W  = 18,
  parameter bit NEGATE = 1'b0
) (
  input  logic                         CLK,
  input  logic                         RSTN,
  input  logic                         en,
  input  logic signed [IF_W-1:0]       if_data,
  input  logic signed [DDS_W-1:0]      dds,
  output logic signed [IF_W+DDS_W-1:0] prod
);
  localparam int PROD_W = IF_W + DDS_W;

  logic signed [PROD_W-1:0] raw_s;
  logic signed [PROD_W-1:0] mul_s;

  // Full-precision product, optionally negated for the quadrature arm.
  always_comb begin
    raw_s = PROD_W'(if_data) * PROD_W'(dds);
    if (NEGATE) begin
      mul_s = -raw_s;
    end else begin
      mul_s = raw_s;
    end
  end

  // Capture the product only for accepted samples so it lines up with stage 2.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      prod <= {PROD_W{1'b0}};
    end else if (en) begin
      prod <= mul_s;
    end
  end
endmodule

// File: rtl/gnss_carrier_wipeoff_accum.sv
// GNSS carrier wipe-off and integrate-and-dump. Mixes IF samples with the DDS
// sine/cosine, sums I/Q over DUMP_LEN accepted samples and hands each dump to
// the tracking loop through a one-entry valid/ready register.
// Optional feature: define GNSS_CWA_SAT_EN to clip the scaled result to OUT_W
// bits (and report SAT); otherwise the scaled result wraps and SAT stays 0.
module gnss_carrier_wipeoff_accum
  import gnss_dsp_pkg::*;
#(
  parameter int DDS_W      = DDS_W_DEF,
  parameter int IF_W       = IF_W_DEF,
  parameter int DUMP_LEN_W = DUMP_LEN_W_DEF,
  parameter int ACC_W      = ACC_W_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  parameter int SHIFT      = SHIFT_DEF
) (
  input logic                         CLK,
  input logic                         RSTN,
  gnss_carrier_wipeoff_accum_if.slave bus
);
  localparam int PROD_W = IF_W + DDS_W;
  localparam logic [DUMP_LEN_W-1:0] LEN_ZERO = {DUMP_LEN_W{1'b0}};
  localparam logic [DUMP_LEN_W-1:0] LEN_ONE  = {{(DUMP_LEN_W-1){1'b0}}, 1'b1};

  cwa_state_e              state_r;
  cwa_state_e              state_nxt_s;
  logic                    run_ok_s;
  logic                    start_s;
  logic                    accept_s;
  logic                    last_s;
  logic [DUMP_LEN_W-1:0]   eff_len_s;
  logic [DUMP_LEN_W-1:0]   len_r;
  logic [DUMP_LEN_W-1:0]   cnt_r;
  logic                    pv_r;
  logic                    pl_r;
  logic signed [PROD_W-1:0] p_i_s;
  logic signed [PROD_W-1:0] p_q_s;
  logic signed [ACC_W-1:0] acc_i_r;
  logic signed [ACC_W-1:0] acc_q_r;
  logic signed [ACC_W-1:0] sum_i_s;
  logic signed [ACC_W-1:0] sum_q_s;
  logic                    dump_s;
  logic                    load_s;
  logic                    ovr_s;
  logic signed [OUT_W-1:0] res_i_s;
  logic signed [OUT_W-1:0] res_q_s;
  logic                    res_sat_s;
  logic signed [OUT_W-1:0] out_i_r;
  logic signed [OUT_W-1:0] out_q_r;
  logic                    out_valid_r;
  logic                    ovr_r;
  logic                    sat_r;

  assign bus.OUT_I     = out_i_r;
  assign bus.OUT_Q     = out_q_r;
  assign bus.OUT_VALID = out_valid_r;
  assign bus.OVERRUN   = ovr_r;
  assign bus.SAT       = sat_r;

  // Sample acceptance, period boundary and output-register handshake decode.
  always_comb begin
    run_ok_s = bus.ENABLE & bus.INIT_OVER;
    start_s  = (state_r == IDLE) & run_ok_s;
    accept_s = (state_r == RUN) & run_ok_s & bus.IF_VALID;
    last_s   = accept_s & (cnt_r == (len_r - LEN_ONE));
    if (bus.DUMP_LEN == LEN_ZERO) begin
      eff_len_s = LEN_ONE;
    end else begin
      eff_len_s = bus.DUMP_LEN;
    end
    dump_s = pv_r & pl_r;
    load_s = dump_s & (~out_valid_r | bus.OUT_READY);
    ovr_s  = dump_s & out_valid_r & ~bus.OUT_READY;
  end

  // Next-state logic: run while enabled and the DDS is initialised.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (run_ok_s) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (!run_ok_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Sample counter and period length, re-latched at every period start.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cnt_r <= LEN_ZERO;
      len_r <= LEN_ONE;
    end else if (start_s) begin
      cnt_r <= LEN_ZERO;
      len_r <= eff_len_s;
    end else if (accept_s) begin
      if (last_s) begin
        cnt_r <= LEN_ZERO;
        len_r <= eff_len_s;
      end else begin
        cnt_r <= cnt_r + LEN_ONE;
      end
    end
  end

  carrier_mix_mult #(.IF_W(IF_W), .DDS_W(DDS_W), .NEGATE(1'b0)) u_mix_i (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .en      (accept_s),
    .if_data (bus.IF_DATA),
    .dds     (bus.COSINE),
    .prod    (p_i_s)
  );

  carrier_mix_mult #(.IF_W(IF_W), .DDS_W(DDS_W), .NEGATE(1'b1)) u_mix_q (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .en      (accept_s),
    .if_data (bus.IF_DATA),
    .dds     (bus.SINE),
    .prod    (p_q_s)
  );

  // Stage-1 qualifiers travelling with the registered products.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      pv_r <= 1'b0;
      pl_r <= 1'b0;
    end else begin
      pv_r <= accept_s;
      pl_r <= last_s;
    end
  end

  // Running sums including the product now in stage 2; the dump value when it is the last.
  always_comb begin
    sum_i_s = acc_i_r + {{(ACC_W-PROD_W){p_i_s[PROD_W-1]}}, p_i_s};
    sum_q_s = acc_q_r + {{(ACC_W-PROD_W){p_q_s[PROD_W-1]}}, p_q_s};
  end

  // Accumulators: cleared on period start and after each dump without a gap cycle.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      acc_i_r <= {ACC_W{1'b0}};
      acc_q_r <= {ACC_W{1'b0}};
    end else if (start_s) begin
      acc_i_r <= {ACC_W{1'b0}};
      acc_q_r <= {ACC_W{1'b0}};
    end else if (pv_r) begin
      if (pl_r) begin
        acc_i_r <= {ACC_W{1'b0}};
        acc_q_r <= {ACC_W{1'b0}};
      end else begin
        acc_i_r <= sum_i_s;
        acc_q_r <= sum_q_s;
      end
    end
  end

`ifdef GNSS_CWA_SAT_EN
  clip_t clip_i_s;
  clip_t clip_q_s;

  // Scale the dump value and clip each channel into the output range.
  always_comb begin
    clip_i_s  = sat_clip(CLIP_W'(sum_i_s >>> SHIFT), OUT_W);
    clip_q_s  = sat_clip(CLIP_W'(sum_q_s >>> SHIFT), OUT_W);
    res_i_s   = OUT_W'(clip_i_s.val);
    res_q_s   = OUT_W'(clip_q_s.val);
    res_sat_s = clip_i_s.sat | clip_q_s.sat;
  end
`else
  // Scale the dump value; the low OUT_W bits are kept, so large sums wrap.
  always_comb begin
    res_i_s   = OUT_W'(sum_i_s >>> SHIFT);
    res_q_s   = OUT_W'(sum_q_s >>> SHIFT);
    res_sat_s = 1'b0;
  end
`endif

  // One-entry output register: a dump into a stalled full register is dropped.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      out_i_r     <= {OUT_W{1'b0}};
      out_q_r     <= {OUT_W{1'b0}};
      out_valid_r <= 1'b0;
      ovr_r       <= 1'b0;
      sat_r       <= 1'b0;
    end else begin
      ovr_r <= ovr_s;
      if (load_s) begin
        out_i_r     <= res_i_s;
        out_q_r     <= res_q_s;
        sat_r       <= res_sat_s;
        out_valid_r <= 1'b1;
      end else if (out_valid_r && bus.OUT_READY) begin
        out_valid_r <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_gnss_carrier_wipeoff_accum.sv
// Bench for gnss_carrier_wipeoff_accum: directed scenarios with literal
// expectations plus a randomized run, all checked every cycle against a
// sum-of-products reference model of the integrate-and-dump behaviour.
module tb_gnss_carrier_wipeoff_accum;

  localparam int SHIFT_TB = 0;

  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  gnss_carrier_wipeoff_accum_if #(.DDS_W(18), .IF_W(4), .DUMP_LEN_W(16), .OUT_W(16)) bus ();

  gnss_carrier_wipeoff_accum #(
    .DDS_W(18), .IF_W(4), .DUMP_LEN_W(16), .ACC_W(40), .OUT_W(16), .SHIFT(SHIFT_TB)
  ) dut (
    .CLK  (clk),
    .RSTN (rstn),
    .bus  (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit tog_mode = 1'b0;
  bit rnd_mode = 1'b0;

  // Reference model state
  typedef struct { longint i; longint q; longint due; } res_t;
  res_t   pend[$];
  bit     m_run = 1'b0;
  int     m_cnt = 0;
  int     m_len = 1;
  longint m_si = 0, m_sq = 0, m_edge = 0;
  bit     m_valid = 1'b0, m_ovr = 1'b0, m_sat = 1'b0;
  longint m_i = 0, m_q = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual %0d required %0d at t=%0t", nm, act, exp, $time);
  endtask

  // Map an exact sum onto the 16-bit output value
  task automatic scale(input longint s, output longint v, output bit c);
    longint r;
    logic signed [15:0] w;
    r = s >>> SHIFT_TB;
    c = 1'b0;
`ifdef GNSS_CWA_SAT_EN
    if (r > 32767) begin v = 32767; c = 1'b1; end
    else if (r < -32768) begin v = -32768; c = 1'b1; end
    else v = r;
`else
    w = r[15:0];
    v = w;
`endif
  endtask

  task automatic model_reset();
    pend.delete();
    m_run = 1'b0; m_cnt = 0; m_len = 1; m_si = 0; m_sq = 0; m_edge = 0;
    m_valid = 1'b0; m_ovr = 1'b0; m_sat = 1'b0; m_i = 0; m_q = 0;
  endtask

  task automatic model_step();
    res_t   head;
    longint vi, vq;
    bit     ci, cq;
    int     dl;
    m_edge++;
    m_ovr = 1'b0;
    // result delivery to the one-entry output slot
    if (pend.size() > 0 && pend[0].due == m_edge) begin
      head = pend.pop_front();
      if (!m_valid || bus.OUT_READY) begin
        scale(head.i, vi, ci);
        scale(head.q, vq, cq);
        m_i = vi; m_q = vq; m_sat = ci | cq; m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && bus.OUT_READY) begin
      m_valid = 1'b0;
    end
    // integration over accepted samples
    dl = (bus.DUMP_LEN == 16'd0) ? 1 : int'(bus.DUMP_LEN);
    if (!m_run) begin
      if (bus.ENABLE && bus.INIT_OVER) begin
        m_run = 1'b1; m_len = dl; m_cnt = 0; m_si = 0; m_sq = 0;
      end
    end else if (!(bus.ENABLE && bus.INIT_OVER)) begin
      m_run = 1'b0;
    end else if (bus.IF_VALID) begin
      m_si += longint'(bus.IF_DATA) * longint'(bus.COSINE);
      m_sq -= longint'(bus.IF_DATA) * longint'(bus.SINE);
      m_cnt++;
      if (m_cnt == m_len) begin
        pend.push_back('{m_si, m_sq, m_edge + 1});
        m_si = 0; m_sq = 0; m_cnt = 0; m_len = dl;
      end
    end
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn) model_reset();
    else model_step();
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    check("cyc_out_valid", bus.OUT_VALID, m_valid);
    check("cyc_overrun", bus.OVERRUN, m_ovr);
    if (m_valid) begin
      check("cyc_out_i", bus.OUT_I, m_i);
      check("cyc_out_q", bus.OUT_Q, m_q);
      check("cyc_sat", bus.SAT, m_sat);
    end
  end

  task automatic tick();
    @(negedge clk);
    if (tog_mode) bus.IF_VALID = ~bus.IF_VALID;
    if (rnd_mode) begin
      bus.IF_DATA   = 4'($urandom);
      bus.SINE      = 18'($urandom);
      bus.COSINE    = 18'($urandom);
      bus.IF_VALID  = ($urandom_range(0, 3) != 0);
      bus.OUT_READY = ($urandom_range(0, 9) < 7);
      bus.ENABLE    = ($urandom_range(0, 99) != 0);
      bus.INIT_OVER = ($urandom_range(0, 99) != 0);
      bus.DUMP_LEN  = 16'($urandom_range(0, 6));
    end
  endtask

  task automatic wait_valid(input int budget, output int waited);
    waited = 0;
    while (!bus.OUT_VALID && waited < budget) begin
      tick();
      waited++;
    end
    check("wait_valid", bus.OUT_VALID, 1);
  endtask

  task automatic drain();
    tog_mode = 1'b0; rnd_mode = 1'b0;
    bus.ENABLE = 1'b0; bus.IF_VALID = 1'b0; bus.OUT_READY = 1'b1;
    repeat (5) tick();
  endtask

  task automatic stim1(input bit ready);
    bus.DUMP_LEN = 16'd4; bus.IF_DATA = 4'sd1; bus.COSINE = 18'sd1000; bus.SINE = 18'sd0;
    bus.IF_VALID = 1'b1; bus.OUT_READY = ready; bus.INIT_OVER = 1'b1; bus.ENABLE = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int ovr_seen;
    rstn = 1'b0;
    bus.INIT_OVER = 1'b0; bus.ENABLE = 1'b0; bus.DUMP_LEN = 16'd0;
    bus.IF_DATA = 4'sd0; bus.IF_VALID = 1'b0; bus.SINE = 18'sd0; bus.COSINE = 18'sd0;
    bus.OUT_READY = 1'b1;
    repeat (3) tick();
    check("rst_out_valid", bus.OUT_VALID, 0);
    check("rst_out_i", bus.OUT_I, 0);
    check("rst_out_q", bus.OUT_Q, 0);
    check("rst_overrun", bus.OVERRUN, 0);
    check("rst_sat", bus.SAT, 0);
    rstn = 1'b1;
    tick();

    // 1: continuous samples, back-to-back periods of 4
    stim1(1'b1);
    wait_valid(20, w);
    check("t1_latency", w, 6);
    check("t1_out_i", bus.OUT_I, 4000);
    check("t1_out_q", bus.OUT_Q, 0);
    check("t1_model_i", m_i, 4000);
    tick();
    wait_valid(20, w);
    check("t1_period", w + 1, 4);
    check("t1_out_i_2", bus.OUT_I, 4000);
    drain();

    // 2: valid every other cycle
    bus.DUMP_LEN = 16'd3; bus.IF_DATA = 4'sd2; bus.COSINE = -18'sd5; bus.SINE = 18'sd7;
    bus.IF_VALID = 1'b1; tog_mode = 1'b1; bus.ENABLE = 1'b1;
    wait_valid(30, w);
    check("t2_out_i", bus.OUT_I, -30);
    check("t2_out_q", bus.OUT_Q, -42);
    check("t2_model_q", m_q, -42);
    drain();

    // 3: consumer stalled across several dumps
    bus.DUMP_LEN = 16'd2; bus.IF_DATA = 4'sd1; bus.COSINE = 18'sd100; bus.SINE = 18'sd0;
    bus.IF_VALID = 1'b1; bus.OUT_READY = 1'b0; bus.ENABLE = 1'b1;
    wait_valid(20, w);
    check("t3_first_i", bus.OUT_I, 200);
    ovr_seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.OVERRUN) ovr_seen++;
      check("t3_hold_i", bus.OUT_I, 200);
    end
    check("t3_overruns", ovr_seen, 4);
    bus.ENABLE = 1'b0;
    repeat (4) tick();
    check("t3_still_valid", bus.OUT_VALID, 1);
    check("t3_still_i", bus.OUT_I, 200);
    bus.OUT_READY = 1'b1;
    tick();
    check("t3_release", bus.OUT_VALID, 0);
    drain();

    // 4: abort after 2 of 4 samples, then restart
    stim1(1'b1);
    repeat (3) tick();
    bus.ENABLE = 1'b0;
    repeat (3) tick();
    check("t4_no_output", bus.OUT_VALID, 0);
    bus.ENABLE = 1'b1;
    wait_valid(20, w);
    check("t4_latency", w, 6);
    check("t4_out_i", bus.OUT_I, 4000);
    drain();

    // 5: asynchronous reset while a result is held
    stim1(1'b0);
    wait_valid(20, w);
    repeat (2) tick();
    #2 rstn = 1'b0;
    #1;
    check("t5_out_valid", bus.OUT_VALID, 0);
    check("t5_out_i", bus.OUT_I, 0);
    check("t5_out_q", bus.OUT_Q, 0);
    check("t5_overrun", bus.OVERRUN, 0);
    check("t5_sat", bus.SAT, 0);
    bus.ENABLE = 1'b0; bus.OUT_READY = 1'b1;
    tick();
    rstn = 1'b1;
    repeat (3) tick();
    check("t5_idle", bus.OUT_VALID, 0);
    stim1(1'b1);
    wait_valid(20, w);
    check("t5_restart_latency", w, 6);
    check("t5_restart_i", bus.OUT_I, 4000);
    drain();

    // 6: single-sample period with a -2^20 quadrature sum
    bus.DUMP_LEN = 16'd1; bus.IF_DATA = -4'sd8; bus.SINE = -18'sd131072; bus.COSINE = 18'sd0;
    bus.IF_VALID = 1'b1; bus.ENABLE = 1'b1;
    wait_valid(20, w);
    check("t6_out_i", bus.OUT_I, 0);
`ifdef GNSS_CWA_SAT_EN
    check("t6_out_q", bus.OUT_Q, -32768);
    check("t6_sat", bus.SAT, 1);
`else
    check("t6_out_q", bus.OUT_Q, 0);
    check("t6_sat", bus.SAT, 0);
`endif
    drain();

    // 7: randomized traffic against the model
    bus.INIT_OVER = 1'b1;
    rnd_mode = 1'b1;
    repeat (3000) tick();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
